// File: rtl/vga_layer_mixer_if.sv
// Timing + pixel bus shared by the layer mixer input (from draw_bg) and its output.
interface vga_layer_mixer_if #(
    parameter int CNT_W = 11,
    parameter int RGB_W = 12
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_layer_mixer.sv
// N-layer pixel compositor: fixed index priority (highest index wins), colour-key
// transparency, frame-synchronous layer mask update, per-frame overlap flag.
// Two-stage pipeline: stage 1 resolves the winner, stage 2 forms the output pixel.
// Optional feature macro VGA_MIX_BLEND_EN: per-layer 50/50 blend with the layer below.
module vga_layer_mixer #(
    parameter int                    N_LAYERS  = 4,
    parameter int                    RGB_W     = 12,
    parameter int                    CNT_W     = 11,
    parameter logic [RGB_W-1:0]      KEY_COLOR = RGB_W'(12'hF0F),
    parameter logic [N_LAYERS-1:0]   MASK_RST  = '1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    vga_layer_mixer_if.slave            vga_in,
    vga_layer_mixer_if.master           vga_out,
    input  logic [N_LAYERS-1:0]         layer_on,
    input  logic [N_LAYERS*RGB_W-1:0]   layer_rgb,
    input  logic [N_LAYERS-1:0]         cfg_mask,
    input  logic [N_LAYERS-1:0]         cfg_blend,
    input  logic                        cfg_wr,
    output logic                        cfg_pending,
    output logic [3:0]                  top_layer,
    output logic                        collision_frame
);
    logic                fs;
    logic [N_LAYERS-1:0] active_mask, shadow_mask, eff_mask;
    assign fs = (vga_in.hcount == '0) && (vga_in.vcount == '0);

    // Mask config: a write on the frame-start pixel takes effect at once, otherwise
    // it waits in the shadow until the next frame start (last write wins).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_mask <= MASK_RST;
            shadow_mask <= '0;
            cfg_pending <= 1'b0;
        end else if (cfg_wr && fs) begin
            active_mask <= cfg_mask;
            cfg_pending <= 1'b0;
        end else if (cfg_wr) begin
            shadow_mask <= cfg_mask;
            cfg_pending <= 1'b1;
        end else if (fs && cfg_pending) begin
            active_mask <= shadow_mask;
            cfg_pending <= 1'b0;
        end
    end

    // Mask seen by the frame-start pixel already includes the update landing on it.
    always_comb begin
        eff_mask = active_mask;
        if (fs && cfg_wr)           eff_mask = cfg_mask;
        else if (fs && cfg_pending) eff_mask = shadow_mask;
    end

`ifdef VGA_MIX_BLEND_EN
    localparam int CH_W = RGB_W / 3;
    logic [N_LAYERS-1:0] active_blend, shadow_blend, eff_blend;

    // Blend config follows exactly the same shadow/apply timing as the mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_blend <= '0;
            shadow_blend <= '0;
        end else if (cfg_wr && fs) begin
            active_blend <= cfg_blend;
        end else if (cfg_wr) begin
            shadow_blend <= cfg_blend;
        end else if (fs && cfg_pending) begin
            active_blend <= shadow_blend;
        end
    end

    // Effective blend mask for the current pixel.
    always_comb begin
        eff_blend = active_blend;
        if (fs && cfg_wr)           eff_blend = cfg_blend;
        else if (fs && cfg_pending) eff_blend = shadow_blend;
    end
`else
    logic unused_blend;
    assign unused_blend = ^cfg_blend;
`endif

    logic [3:0]       win, n_vis;
    logic [RGB_W-1:0] win_rgb;
`ifdef VGA_MIX_BLEND_EN
    logic [RGB_W-1:0] under_rgb;
    logic             win_blend;
`endif

    // Priority scan low->high: last visible layer wins; previous winner becomes "underlying".
    always_comb begin
        win     = 4'hF;
        win_rgb = vga_in.rgb;
        n_vis   = '0;
`ifdef VGA_MIX_BLEND_EN
        under_rgb = vga_in.rgb;
        win_blend = 1'b0;
`endif
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer_on[i] && eff_mask[i] && (layer_rgb[i*RGB_W +: RGB_W] != KEY_COLOR)) begin
`ifdef VGA_MIX_BLEND_EN
                under_rgb = win_rgb;
                win_blend = eff_blend[i];
`endif
                win_rgb = layer_rgb[i*RGB_W +: RGB_W];
                win     = 4'(i);
                n_vis   = n_vis + 4'd1;
            end
        end
    end

    logic [CNT_W-1:0] s1_h, s1_v;
    logic             s1_hs, s1_vs, s1_hb, s1_vb, s1_fs, s1_ovl;
    logic [RGB_W-1:0] s1_bg, s1_rgb;
    logic [3:0]       s1_win;
`ifdef VGA_MIX_BLEND_EN
    logic [RGB_W-1:0] s1_under;
    logic             s1_blend;
`endif

    // Stage 1: register timing, background and the resolved winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_h <= '0; s1_v <= '0; s1_hs <= 1'b0; s1_vs <= 1'b0;
            s1_hb <= 1'b0; s1_vb <= 1'b0; s1_fs <= 1'b0; s1_ovl <= 1'b0;
            s1_bg <= '0; s1_rgb <= '0; s1_win <= 4'hF;
`ifdef VGA_MIX_BLEND_EN
            s1_under <= '0; s1_blend <= 1'b0;
`endif
        end else begin
            s1_h <= vga_in.hcount; s1_v <= vga_in.vcount;
            s1_hs <= vga_in.hsync; s1_vs <= vga_in.vsync;
            s1_hb <= vga_in.hblnk; s1_vb <= vga_in.vblnk;
            s1_fs <= fs; s1_ovl <= (n_vis >= 4'd2);
            s1_bg <= vga_in.rgb; s1_rgb <= win_rgb; s1_win <= win;
`ifdef VGA_MIX_BLEND_EN
            s1_under <= under_rgb; s1_blend <= win_blend;
`endif
        end
    end

    logic [RGB_W-1:0] pix;
    logic             blank, acc;
`ifdef VGA_MIX_BLEND_EN
    logic [CH_W:0]    sum;
`endif
    assign blank = s1_hb || s1_vb;

    // Stage 2 pixel: winner or background, optionally averaged with the layer below.
    always_comb begin
        pix = (s1_win == 4'hF) ? s1_bg : s1_rgb;
`ifdef VGA_MIX_BLEND_EN
        sum = '0;
        if (s1_win != 4'hF && s1_blend) begin
            for (int c = 0; c < 3; c++) begin
                sum = {1'b0, s1_rgb[c*CH_W +: CH_W]} + {1'b0, s1_under[c*CH_W +: CH_W]};
                pix[c*CH_W +: CH_W] = sum[CH_W:1];
            end
        end
`endif
    end

    // Stage 2: outputs, blanking override, and per-frame overlap accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_out.hcount <= '0; vga_out.vcount <= '0;
            vga_out.hsync <= 1'b0; vga_out.vsync <= 1'b0;
            vga_out.hblnk <= 1'b0; vga_out.vblnk <= 1'b0;
            vga_out.rgb <= '0; top_layer <= 4'hF;
            acc <= 1'b0; collision_frame <= 1'b0;
        end else begin
            vga_out.hcount <= s1_h; vga_out.vcount <= s1_v;
            vga_out.hsync <= s1_hs; vga_out.vsync <= s1_vs;
            vga_out.hblnk <= s1_hb; vga_out.vblnk <= s1_vb;
            vga_out.rgb <= blank ? '0 : pix;
            top_layer   <= blank ? 4'hF : s1_win;
            if (s1_fs) begin
                collision_frame <= acc;
                acc <= s1_ovl && !blank;
            end else begin
                acc <= acc | (s1_ovl && !blank);
            end
        end
    end
endmodule

// File: tb/tb_vga_layer_mixer.sv
// Scoreboard bench for vga_layer_mixer: driver pushes hand-computed expectations,
// a negedge monitor pops them when the issued pixel reaches the output (2 cycles).
module tb_vga_layer_mixer;
    localparam int N = 4, RGB_W = 12, CNT_W = 11;
`ifdef VGA_MIX_BLEND_EN
    localparam logic [11:0] BL0 = 12'h777, BL1 = 12'h778;
`else
    localparam logic [11:0] BL0 = 12'hFFF, BL1 = 12'hFFF;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_layer_mixer_if #(.CNT_W(CNT_W), .RGB_W(RGB_W)) vin();
    vga_layer_mixer_if #(.CNT_W(CNT_W), .RGB_W(RGB_W)) vout();

    logic [N-1:0]       layer_on, cfg_mask, cfg_blend;
    logic [N*RGB_W-1:0] layer_rgb;
    logic               cfg_wr, cfg_pending, collision_frame;
    logic [3:0]         top_layer;

    vga_layer_mixer dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vin), .vga_out(vout),
        .layer_on(layer_on), .layer_rgb(layer_rgb), .cfg_mask(cfg_mask),
        .cfg_blend(cfg_blend), .cfg_wr(cfg_wr), .cfg_pending(cfg_pending),
        .top_layer(top_layer), .collision_frame(collision_frame)
    );

    typedef struct {
        logic [10:0] h, v;
        logic        hb, vb;
        logic [11:0] rgb;
        logic [3:0]  top;
        logic        col;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0, fails = 0;
    logic issued = 1'b0;
    logic [1:0] iss_d = 2'b00;

    always @(posedge clk) iss_d <= {iss_d[0], issued};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every output pixel that corresponds to an issued input pixel.
    always @(negedge clk) begin
        if (iss_d[1]) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard: output with no expectation queued");
            end else begin
                e = q.pop_front();
                chk("rgb_out", 32'(vout.rgb), 32'(e.rgb));
                chk("top_layer", 32'(top_layer), 32'(e.top));
                chk("collision_frame", 32'(collision_frame), 32'(e.col));
                chk("hcount_out", 32'(vout.hcount), 32'(e.h));
                chk("vcount_out", 32'(vout.vcount), 32'(e.v));
                chk("sync_out", {30'd0, vout.hsync, vout.vsync}, {30'd0, e.h[0], e.v[0]});
                chk("blnk_out", {30'd0, vout.hblnk, vout.vblnk}, {30'd0, e.hb, e.vb});
            end
        end
    end

    task automatic pix(input int h, input int v, input logic hb, input logic vb,
                       input logic [N-1:0] on, input logic [N*RGB_W-1:0] rgbs,
                       input logic [11:0] bg, input logic wr, input logic [N-1:0] m,
                       input logic [N-1:0] b, input logic [11:0] er,
                       input logic [3:0] et, input logic ec);
        exp_t x;
        vin.hcount = h[10:0]; vin.vcount = v[10:0];
        vin.hsync = h[0]; vin.vsync = v[0];
        vin.hblnk = hb; vin.vblnk = vb; vin.rgb = bg;
        layer_on = on; layer_rgb = rgbs;
        cfg_wr = wr; cfg_mask = m; cfg_blend = b;
        issued = 1'b1;
        x.h = h[10:0]; x.v = v[10:0]; x.hb = hb; x.vb = vb;
        x.rgb = er; x.top = et; x.col = ec;
        q.push_back(x);
        @(posedge clk); #1;
        cfg_wr = 1'b0; issued = 1'b0;
    endtask

    task automatic idle(input int n);
        vin.hcount = 11'd1; vin.vcount = 11'd1; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b1; vin.vblnk = 1'b0; vin.rgb = 12'h0;
        layer_on = '0; layer_rgb = '0; cfg_wr = 1'b0; issued = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cfg_mask = '0; cfg_blend = '0;
        idle(3);
        chk("reset rgb_out", 32'(vout.rgb), 32'h0);
        chk("reset top_layer", 32'(top_layer), 32'hF);
        chk("reset cfg_pending", 32'(cfg_pending), 32'h0);
        chk("reset collision_frame", 32'(collision_frame), 32'h0);
        chk("reset hcount_out", 32'(vout.hcount), 32'h0);
        rst_n = 1'b1;

        // frame 0: priority, colour key, single top layer, overlap in blanking
        pix(0, 0, 0, 0, 4'b0000, 48'h0, 12'h123, 0, 0, 0, 12'h123, 4'hF, 0);
        pix(10, 5, 0, 0, 4'b0101, 48'h000_0F0_000_00F, 12'h123, 0, 0, 0, 12'h0F0, 4'd2, 0);
        pix(11, 5, 0, 0, 4'b0001, 48'h000_000_000_F0F, 12'h123, 0, 0, 0, 12'h123, 4'hF, 0);
        pix(12, 5, 0, 0, 4'b1000, 48'hABC_000_000_000, 12'h123, 0, 0, 0, 12'hABC, 4'd3, 0);
        pix(13, 5, 1, 0, 4'b1010, 48'h333_000_111_000, 12'h123, 0, 0, 0, 12'h000, 4'hF, 0);
        // frame 1: collision from frame 0 visible; mid-frame mask write is deferred
        pix(0, 0, 0, 0, 4'b0000, 48'h0, 12'h123, 0, 0, 0, 12'h123, 4'hF, 1);
        pix(20, 7, 0, 1, 4'b1010, 48'h333_000_111_000, 12'h123, 0, 0, 0, 12'h000, 4'hF, 1);
        pix(21, 7, 0, 0, 4'b0010, 48'h000_000_456_000, 12'h123, 1, 4'b1011, 0, 12'h456, 4'd1, 1);
        chk("pending after mid-frame write", 32'(cfg_pending), 32'h1);
        pix(22, 7, 0, 0, 4'b0100, 48'h000_0F0_000_000, 12'h123, 0, 0, 0, 12'h0F0, 4'd2, 1);
        chk("pending held until FS", 32'(cfg_pending), 32'h1);
        // frame 2: mask applies at FS pixel; overlap only in blanking gave no collision
        pix(0, 0, 0, 0, 4'b0100, 48'h000_0F0_000_000, 12'h123, 0, 0, 0, 12'h123, 4'hF, 0);
        chk("pending cleared at FS", 32'(cfg_pending), 32'h0);
        pix(30, 9, 0, 0, 4'b0101, 48'h000_0F0_000_00F, 12'h123, 0, 0, 0, 12'h00F, 4'd0, 0);
        pix(100, 200, 0, 0, 4'b1010, 48'h333_000_111_000, 12'h123, 0, 0, 0, 12'h333, 4'd3, 0);
        // frame 3: write on FS cycle applies immediately, never pends
        pix(0, 0, 0, 0, 4'b0100, 48'h000_0F0_000_000, 12'h123, 1, 4'b1111, 4'b1000, 12'h0F0, 4'd2, 1);
        chk("pending after FS write", 32'(cfg_pending), 32'h0);
        pix(40, 1, 0, 0, 4'b0000, 48'h0, 12'h123, 0, 0, 0, 12'h123, 4'hF, 1);
        // frame 4: blend (or opaque) top layer; back-to-back writes, last wins
        pix(0, 0, 0, 0, 4'b0000, 48'h0, 12'h123, 0, 0, 0, 12'h123, 4'hF, 0);
        pix(5, 5, 0, 0, 4'b1000, 48'hFFF_000_000_000, 12'h000, 0, 0, 0, BL0, 4'd3, 0);
        pix(6, 5, 0, 0, 4'b1001, 48'hFFF_000_000_001, 12'h000, 0, 0, 0, BL1, 4'd3, 0);
        pix(7, 5, 0, 0, 4'b0000, 48'h0, 12'h123, 1, 4'b0001, 0, 12'h123, 4'hF, 0);
        chk("pending after first write", 32'(cfg_pending), 32'h1);
        pix(8, 5, 0, 0, 4'b0000, 48'h0, 12'h123, 1, 4'b0011, 0, 12'h123, 4'hF, 0);
        chk("pending after overwrite", 32'(cfg_pending), 32'h1);
        // frame 5: mask 0011 active
        pix(0, 0, 0, 0, 4'b0010, 48'h000_000_456_000, 12'h123, 0, 0, 0, 12'h456, 4'd1, 1);
        chk("pending cleared at FS 2", 32'(cfg_pending), 32'h0);
        pix(9, 9, 0, 0, 4'b0100, 48'h000_0F0_000_000, 12'h123, 0, 0, 0, 12'h123, 4'hF, 1);
        // frame 6: overlap, pending write, then reset mid-frame
        pix(0, 0, 0, 0, 4'b0000, 48'h0, 12'h123, 0, 0, 0, 12'h123, 4'hF, 0);
        pix(50, 3, 0, 0, 4'b0011, 48'h000_000_111_00F, 12'h123, 0, 0, 0, 12'h111, 4'd1, 0);
        pix(51, 3, 0, 0, 4'b0000, 48'h0, 12'h123, 1, 4'b0001, 0, 12'h123, 4'hF, 0);
        chk("pending before reset", 32'(cfg_pending), 32'h1);
        idle(3);
        rst_n = 1'b0;
        idle(2);
        chk("mid reset cfg_pending", 32'(cfg_pending), 32'h0);
        chk("mid reset collision_frame", 32'(collision_frame), 32'h0);
        chk("mid reset rgb_out", 32'(vout.rgb), 32'h0);
        chk("mid reset top_layer", 32'(top_layer), 32'hF);
        rst_n = 1'b1;
        // first frame after reset: mask back to all-on, accumulator clean
        pix(0, 0, 0, 0, 4'b0100, 48'h000_0F0_000_000, 12'h123, 0, 0, 0, 12'h0F0, 4'd2, 0);
        pix(1, 0, 0, 0, 4'b0000, 48'h0, 12'h123, 0, 0, 0, 12'h123, 4'hF, 0);
        idle(4);
        chk("scoreboard drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
